// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus issue sequencer feeding a UART transmitter.
// Bytes are pushed at full clock rate and handed over one at a time through
// the sdata / tx_start / tx_busy handshake, never while the transmitter is busy.
module uart_tx_feeder #(
   parameter  int DEPTH        = 16,
   parameter  int BUSY_TIMEOUT = 8,
   localparam int ADDR_W       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        wr_data,
   input  logic              wr_en,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              idle,
   output logic [7:0]        sdata,
   output logic              tx_start,
   input  logic              tx_busy
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_e;

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        sdata_q, sdata_d;
   logic              tx_start_q, tx_start_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   state_e            state_q, state_d;

   logic do_write;
   logic do_pop;

   // Status flags come only from registered state, never from wr_en.
   assign full     = (count_q == CNT_FULL);
   assign empty    = (count_q == '0);
   assign idle     = empty && (state_q == S_IDLE);
   assign count    = count_q;
   assign overflow = overflow_q;
   assign sdata    = sdata_q;
   assign tx_start = tx_start_q;

   // A pop cannot free a slot for a write on the same edge while full.
   assign do_write = wr_en && !full && !flush;
   assign do_pop   = (state_q == S_IDLE) && !empty && !tx_busy && !flush;

   // Next-state logic for FIFO pointers, occupancy and the issue sequencer.
   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      sdata_d    = sdata_q;
      tx_start_d = 1'b0;
      tmo_d      = tmo_q;
      state_d    = state_q;

      // A write dropped because of flush does not count as an overflow.
      if (wr_en && full && !flush) begin
         overflow_d = 1'b1;
      end

      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (do_write) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         end
         if (do_write && !do_pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (do_pop && !do_write) begin
            count_d = count_q - CNT_W'(1);
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (do_pop) begin
               sdata_d    = mem_q[rd_ptr_q];
               tx_start_d = 1'b1;
               tmo_d      = '0;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            // A transmitter that never acknowledges costs the byte, not the queue.
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state registers; reset drops everything, queued bytes included.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         sdata_q    <= 8'h00;
         tx_start_q <= 1'b0;
         tmo_q      <= '0;
         state_q    <= S_IDLE;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         sdata_q    <= sdata_d;
         tx_start_q <= tx_start_d;
         tmo_q      <= tmo_d;
         state_q    <= state_d;
      end
   end

   // Byte storage, written at the write pointer.
   always_ff @(posedge clk) begin
      // NOTE: the array is not reset; count and pointers decide which entries are valid.
      if (do_write) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a simple transmitter busy model
// and a byte scoreboard checked on every tx_start pulse.
module tb_uart_tx_feeder;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       flush;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       idle;
   logic [7:0] sdata;
   logic       tx_start;
   logic       tx_busy;

   int checks   = 0;
   int failures = 0;

   // transmitter model controls
   int busy_len  = 10;
   int busy_left = 0;
   bit force_hi  = 1'b0;
   bit no_resp   = 1'b0;

   // scoreboard and monitor state
   logic [7:0] exp_q[$];
   int         pulses = 0;
   int         cyc = 0;
   int         start_cyc_last = 0;
   int         start_cyc_prev = 0;
   logic [7:0] last_sdata = 8'h00;
   logic       prev_start = 1'b0;
   bit         track_max = 1'b0;
   int         max_count = 0;

   typedef struct {
      logic       wr_en;
      logic       flush;
      logic [7:0] data;
      logic       accept;
      int         exp_count;
      logic       exp_full;
      logic       exp_empty;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[17];

   uart_tx_feeder #(.DEPTH(DEPTH), .BUSY_TIMEOUT(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .flush    (flush),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .idle     (idle),
      .sdata    (sdata),
      .tx_start (tx_start),
      .tx_busy  (tx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Transmitter: busy rises the edge after tx_start, stays high busy_len cycles.
   always @(posedge clk) begin
      if (reset) begin
         tx_busy   <= 1'b0;
         busy_left <= 0;
      end else if (force_hi) begin
         tx_busy <= 1'b1;
      end else if (tx_start && !no_resp) begin
         tx_busy   <= 1'b1;
         busy_left <= busy_len - 1;
      end else if (busy_left > 0) begin
         busy_left <= busy_left - 1;
      end else begin
         tx_busy <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every issue must be legal and match the scoreboard head.
   always @(negedge clk) begin
      if (reset) begin
         last_sdata = 8'h00;
         prev_start = 1'b0;
      end else begin
         if (track_max && int'(count) > max_count) max_count = int'(count);
         if (tx_start) begin
            pulses++;
            check("start_while_busy", tx_busy, 0);
            check("pulse_width", prev_start, 0);
            check("issue_with_empty_scoreboard", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("issue_order", sdata, exp_q.pop_front());
            start_cyc_prev = start_cyc_last;
            start_cyc_last = cyc;
            last_sdata     = sdata;
         end else begin
            check("sdata_hold", sdata, last_sdata);
         end
         prev_start = tx_start;
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_write(input logic [7:0] d, input bit expect_issue);
      wr_en   = 1'b1;
      wr_data = d;
      if (expect_issue) exp_q.push_back(d);
      cycle();
      wr_en = 1'b0;
   endtask

   task automatic wait_busy(input logic level, input int budget, input string name);
      int n = 0;
      while (tx_busy !== level && n < budget) begin
         cycle();
         n++;
      end
      check(name, tx_busy, level);
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n = 0;
      while (!(exp_q.size() == 0 && idle === 1'b1 && tx_busy === 1'b0) && n < budget) begin
         cycle();
         n++;
      end
      check(name, (exp_q.size() == 0 && idle === 1'b1 && tx_busy === 1'b0), 1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_count"}, count, 0);
      check({tag, "_empty"}, empty, 1);
      check({tag, "_full"}, full, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_idle"}, idle, 1);
      check({tag, "_sdata"}, sdata, 8'h00);
      check({tag, "_tx_start"}, tx_start, 0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      exp_q.delete();
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;

      // fill/overflow table: 16 accepted writes then one dropped write
      for (int i = 0; i < 17; i++) begin
         vecs[i].wr_en     = 1'b1;
         vecs[i].flush     = 1'b0;
         vecs[i].data      = 8'h10 + 8'(i);
         vecs[i].accept    = (i < DEPTH);
         vecs[i].exp_count = (i < DEPTH) ? i + 1 : DEPTH;
         vecs[i].exp_full  = (i >= DEPTH - 1);
         vecs[i].exp_empty = 1'b0;
         vecs[i].exp_ovf   = (i >= DEPTH);
      end

      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      flush   = 1'b0;
      cycle();
      check_reset_values("in_reset");
      cycle();
      reset = 1'b0;
      check_reset_values("after_reset");

      // single byte
      busy_len = 10;
      drive_write(8'hA5, 1'b1);
      check("single_count_after_e0", count, 1);
      check("single_no_start_e0", tx_start, 0);
      cycle();
      check("single_start_e1", tx_start, 1);
      check("single_sdata", sdata, 8'hA5);
      check("single_count_popped", count, 0);
      cycle();
      check("single_start_one_cycle", tx_start, 0);
      wait_busy(1'b1, 10, "single_busy_rise");
      wait_busy(1'b0, 30, "single_busy_fall");
      check("single_not_idle_at_fall", idle, 0);
      cycle();
      cycle();
      check("single_idle_after_fall", idle, 1);

      // burst of four
      busy_len = 20;
      p0 = pulses;
      for (int i = 1; i <= 4; i++) drive_write(8'(i), 1'b1);
      wait_drain(400, "burst_drain");
      check("burst_pulses", pulses - p0, 4);

      // fill and overflow with busy held high
      busy_len = 4;
      force_hi = 1'b1;
      cycle();
      cycle();
      p0 = pulses;
      for (int i = 0; i < 17; i++) begin
         wr_en   = vecs[i].wr_en;
         flush   = vecs[i].flush;
         wr_data = vecs[i].data;
         if (vecs[i].accept) exp_q.push_back(vecs[i].data);
         cycle();
         check($sformatf("fill_count_%0d", i), count, vecs[i].exp_count);
         check($sformatf("fill_full_%0d", i), full, vecs[i].exp_full);
         check($sformatf("fill_empty_%0d", i), empty, vecs[i].exp_empty);
         check($sformatf("fill_ovf_%0d", i), overflow, vecs[i].exp_ovf);
      end
      wr_en = 1'b0;
      flush = 1'b0;
      check("fill_no_issue_while_busy", pulses - p0, 0);
      force_hi = 1'b0;
      wait_drain(1000, "fill_drain");
      check("fill_pulses", pulses - p0, 16);
      check("fill_last_byte", last_sdata, 8'h1F);
      check("fill_overflow_sticky", overflow, 1);

      // wrap-around
      busy_len  = 3;
      max_count = 0;
      track_max = 1'b1;
      p0 = pulses;
      for (int i = 0; i < 12; i++) drive_write(8'h40 + 8'(i), 1'b1);
      wait_drain(1000, "wrap_drain_1");
      for (int i = 0; i < 12; i++) drive_write(8'h80 + 8'(i), 1'b1);
      wait_drain(1000, "wrap_drain_2");
      track_max = 1'b0;
      check("wrap_pulses", pulses - p0, 24);
      check("wrap_max_count_le_12", max_count <= 12, 1);

      // flush with a byte in flight and a simultaneous write
      apply_reset();
      check("flush_pre_overflow", overflow, 0);
      busy_len = 10;
      p0 = pulses;
      drive_write(8'h50, 1'b1);
      for (int i = 1; i < 6; i++) drive_write(8'h50 + 8'(i), 1'b0);
      check("flush_queued", count, 5);
      flush   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'hFF;
      cycle();
      flush = 1'b0;
      wr_en = 1'b0;
      check("flush_count", count, 0);
      check("flush_empty", empty, 1);
      check("flush_overflow", overflow, 0);
      wait_drain(200, "flush_drain");
      repeat (30) cycle();
      check("flush_pulses", pulses - p0, 1);

      // timeout: transmitter never raises busy
      no_resp = 1'b1;
      p0 = pulses;
      drive_write(8'hB0, 1'b1);
      drive_write(8'hB1, 1'b1);
      wait_drain(200, "timeout_drain");
      check("timeout_pulses", pulses - p0, 2);
      check("timeout_gap", start_cyc_last - start_cyc_prev, 10);
      no_resp = 1'b0;

      // asynchronous reset while waiting for the transmitter to finish
      busy_len = 10;
      drive_write(8'hC0, 1'b1);
      drive_write(8'hC1, 1'b1);
      drive_write(8'hC2, 1'b1);
      wait_busy(1'b1, 10, "reset_busy_rise");
      cycle();
      check("reset_pre_count", count, 2);
      #3;
      reset = 1'b1;
      #1;
      check_reset_values("async_reset");
      exp_q.delete();
      cycle();
      cycle();
      reset = 1'b0;
      p0 = pulses;
      repeat (20) cycle();
      check("post_reset_no_issue", pulses - p0, 0);
      check("post_reset_idle", idle, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
